// File: rtl/lane_deskew_if.sv
// Lane deskew bundle: decoded lane bytes in, byte-aligned lanes and lock status out.
interface lane_deskew_if;
  logic       enable_deskew;
  logic [7:0] lane_0_rx;
  logic [7:0] lane_1_rx;
  logic       data_os;
  logic [7:0] lane_0_out;
  logic [7:0] lane_1_out;
  logic       data_os_out;
  logic       out_valid;
  logic       deskew_done;
  logic       deskew_err;
  logic [2:0] skew_value;
  logic       early_lane;

  modport master (
    output enable_deskew, lane_0_rx, lane_1_rx, data_os,
    input  lane_0_out, lane_1_out, data_os_out, out_valid,
           deskew_done, deskew_err, skew_value, early_lane
  );

  modport slave (
    input  enable_deskew, lane_0_rx, lane_1_rx, data_os,
    output lane_0_out, lane_1_out, data_os_out, out_valid,
           deskew_done, deskew_err, skew_value, early_lane
  );
endinterface

// File: rtl/lane_deskew.sv
// Two-lane deskew: finds SYNC_BYTE on each lane, measures the skew and delays
// the earlier lane through an 8-tap line so both lanes leave byte-aligned.
module lane_deskew #(
  parameter logic [7:0]  SYNC_BYTE = 8'hF0,
  parameter int unsigned MAX_SKEW  = 7
) (
  input logic          enc_clk,
  input logic          rst,
  lane_deskew_if.slave bus
);
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned SKEW_W = 3;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_WAIT_LATE,
    S_LOCKED,
    S_ERROR
  } state_e;

  state_e state_q, state_d;

  logic [SKEW_W-1:0] cnt_q, cnt_d;
  logic [SKEW_W-1:0] skew_q, skew_d;
  logic              early_q, early_d;

  // Tap 0 doubles as the input register; tap k holds the byte from k+1 cycles ago.
  logic [DEPTH-1:0][BYTE_W-1:0] line0_q, line1_q;
  logic                         dos_q;

  logic [BYTE_W-1:0] l0_out_q, l0_out_d;
  logic [BYTE_W-1:0] l1_out_q, l1_out_d;
  logic              dos_out_q, dos_out_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic match0_c, match1_c, late_match_c, locked_c;

  assign match0_c     = (bus.lane_0_rx == SYNC_BYTE);
  assign match1_c     = (bus.lane_1_rx == SYNC_BYTE);
  assign late_match_c = early_q ? match0_c : match1_c;
  assign locked_c     = (state_q == S_LOCKED) && bus.enable_deskew;

  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      skew_q    <= '0;
      early_q   <= 1'b0;
      line0_q   <= '0;
      line1_q   <= '0;
      dos_q     <= 1'b0;
      l0_out_q  <= '0;
      l1_out_q  <= '0;
      dos_out_q <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      skew_q    <= skew_d;
      early_q   <= early_d;
      line0_q   <= {line0_q[DEPTH-2:0], bus.lane_0_rx};
      line1_q   <= {line1_q[DEPTH-2:0], bus.lane_1_rx};
      dos_q     <= bus.data_os;
      l0_out_q  <= l0_out_d;
      l1_out_q  <= l1_out_d;
      dos_out_q <= dos_out_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    skew_d  = skew_q;
    early_d = early_q;

    // Dropping enable wins over any sync match seen in the same cycle.
    if (!bus.enable_deskew) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      skew_d  = '0;
      early_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SEARCH;
          cnt_d   = '0;
          skew_d  = '0;
          early_d = 1'b0;
        end
        S_SEARCH: begin
          if (match0_c && match1_c) begin
            skew_d  = '0;
            early_d = 1'b0;
            state_d = S_LOCKED;
          end else if (match0_c || match1_c) begin
            early_d = match1_c;
            cnt_d   = SKEW_W'(1);
            state_d = S_WAIT_LATE;
          end
        end
        S_WAIT_LATE: begin
          if (late_match_c) begin
            skew_d  = cnt_q;
            state_d = S_LOCKED;
          end else if (cnt_q == SKEW_W'(MAX_SKEW)) begin
            state_d = S_ERROR;
          end else begin
            cnt_d = cnt_q + SKEW_W'(1);
          end
        end
        S_LOCKED, S_ERROR: begin
          state_d = state_q;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Late lane comes from tap 0, early lane from the tap matching the skew.
    l0_out_d  = '0;
    l1_out_d  = '0;
    dos_out_d = 1'b0;
    if (locked_c) begin
      l0_out_d  = early_q ? line0_q[0] : line0_q[skew_q];
      l1_out_d  = early_q ? line1_q[skew_q] : line1_q[0];
      dos_out_d = dos_q;
    end
    valid_d = locked_c;
    done_d  = locked_c;
    err_d   = (state_d == S_ERROR);
  end

  assign bus.lane_0_out  = l0_out_q;
  assign bus.lane_1_out  = l1_out_q;
  assign bus.data_os_out = dos_out_q;
  assign bus.out_valid   = valid_q;
  assign bus.deskew_done = done_q;
  assign bus.deskew_err  = err_q;
  assign bus.skew_value  = skew_q;
  assign bus.early_lane  = early_q;

endmodule

// File: tb/tb_lane_deskew.sv
// Directed bench for lane_deskew: lock at skew 0/1/2/3/7, overflow error,
// data_os alignment, disable and asynchronous reset while locked.
module tb_lane_deskew;
  logic enc_clk = 1'b0;
  logic rst;

  lane_deskew_if bus();

  lane_deskew #(.SYNC_BYTE(8'hF0), .MAX_SKEW(7)) dut (
    .enc_clk(enc_clk),
    .rst    (rst),
    .bus    (bus.slave)
  );

  always #5 enc_clk = ~enc_clk;

  int unsigned n_vec;
  int unsigned n_err;
  int          cyc;
  logic [7:0]  h0 [512];
  logic [7:0]  h1 [512];
  logic        hd [512];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one input vector, record it, then advance to 1 time unit after the edge.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic d);
    bus.lane_0_rx = a;
    bus.lane_1_rx = b;
    bus.data_os   = d;
    h0[cyc] = a;
    h1[cyc] = b;
    hd[cyc] = d;
    @(posedge enc_clk);
    #1;
    cyc++;
  endtask

  // Aligned output: lane latency is 2 cycles plus its delay d0/d1.
  task automatic chk_out(input string tag, input int d0, input int d1);
    chk({tag, "_l0"},  32'(bus.lane_0_out),  32'(h0[cyc-2-d0]));
    chk({tag, "_l1"},  32'(bus.lane_1_out),  32'(h1[cyc-2-d1]));
    chk({tag, "_dos"}, 32'(bus.data_os_out), 32'(hd[cyc-2]));
    chk({tag, "_vld"}, 32'(bus.out_valid),   1);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.lane_0_out, bus.lane_1_out, bus.data_os_out, bus.out_valid,
                bus.deskew_done, bus.deskew_err, bus.skew_value, bus.early_lane});
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    rst   = 1'b0;
    bus.enable_deskew = 1'b0;
    bus.lane_0_rx = 8'h00;
    bus.lane_1_rx = 8'h00;
    bus.data_os   = 1'b0;

    // Reset
    #2;
    chk("reset_outs", all_outs(), 0);
    step(8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    step(8'hF0, 8'hF0, 1'b0);
    chk("idle_no_lock", all_outs(), 0);

    // Zero skew
    bus.enable_deskew = 1'b1;
    step(8'h00, 8'h00, 1'b1);
    step(8'h00, 8'h00, 1'b1);
    step(8'hF0, 8'hF0, 1'b1);
    chk("zs_skew",     32'(bus.skew_value),  0);
    chk("zs_vld_t1",   32'(bus.out_valid),   0);
    step(8'h01, 8'h01, 1'b1);
    chk("zs_l0_sync",  32'(bus.lane_0_out),  'hF0);
    chk("zs_l1_sync",  32'(bus.lane_1_out),  'hF0);
    chk("zs_vld",      32'(bus.out_valid),   1);
    chk("zs_done",     32'(bus.deskew_done), 1);
    for (int i = 2; i < 6; i++) begin
      step(8'(i), 8'(i), 1'b1);
      chk_out("zs_data", 0, 0);
    end

    // One-cycle disable clears flags
    bus.enable_deskew = 1'b0;
    step(8'h00, 8'h00, 1'b0);
    chk("dis_vld",  32'(bus.out_valid),   0);
    chk("dis_done", 32'(bus.deskew_done), 0);
    chk("dis_l0",   32'(bus.lane_0_out),  0);

    // Lane 0 early by 3
    bus.enable_deskew = 1'b1;
    step(8'h00, 8'h00, 1'b0);
    chk("s3_idle_skew", 32'(bus.skew_value), 0);
    step(8'hF0, 8'h20, 1'b0);
    chk("s3_early", 32'(bus.early_lane), 0);
    step(8'h11, 8'h21, 1'b0);
    step(8'h12, 8'h22, 1'b0);
    step(8'h13, 8'hF0, 1'b0);
    chk("s3_skew",  32'(bus.skew_value), 3);
    chk("s3_vld0",  32'(bus.out_valid),  0);
    step(8'h14, 8'h24, 1'b1);
    chk("s3_l0_sync", 32'(bus.lane_0_out), 'hF0);
    chk("s3_l1_sync", 32'(bus.lane_1_out), 'hF0);
    chk("s3_done",    32'(bus.deskew_done), 1);
    for (int j = 5; j < 10; j++) begin
      step(8'(8'h10 + j), 8'(8'h20 + j), 1'(j % 2));
      chk_out("s3_data", 3, 0);
    end

    bus.enable_deskew = 1'b0;
    step(8'h00, 8'h00, 1'b0);

    // Lane 1 early by MAX_SKEW, with an ignored repeat sync on lane 1
    bus.enable_deskew = 1'b1;
    step(8'h00, 8'h00, 1'b0);
    step(8'h30, 8'hF0, 1'b0);
    step(8'h31, 8'h41, 1'b0);
    step(8'h32, 8'hF0, 1'b0);
    step(8'h33, 8'h43, 1'b0);
    step(8'h34, 8'h44, 1'b0);
    step(8'h35, 8'h45, 1'b0);
    step(8'h36, 8'h46, 1'b0);
    step(8'hF0, 8'h47, 1'b0);
    chk("s7_skew",  32'(bus.skew_value), 7);
    chk("s7_early", 32'(bus.early_lane), 1);
    chk("s7_err0",  32'(bus.deskew_err), 0);
    step(8'h38, 8'h48, 1'b0);
    chk("s7_l0_sync", 32'(bus.lane_0_out), 'hF0);
    chk("s7_l1_sync", 32'(bus.lane_1_out), 'hF0);
    for (int j = 9; j < 13; j++) begin
      step(8'(8'h30 + j), 8'(8'h40 + j), 1'b1);
      chk_out("s7_data", 0, 7);
    end
    chk("s7_err1", 32'(bus.deskew_err), 0);

    bus.enable_deskew = 1'b0;
    step(8'h00, 8'h00, 1'b0);

    // Skew too large: lane 0 sync, lane 1 never within MAX_SKEW
    bus.enable_deskew = 1'b1;
    step(8'h00, 8'h00, 1'b0);
    step(8'hF0, 8'h60, 1'b0);
    for (int j = 1; j < 7; j++) step(8'(8'h50 + j), 8'(8'h60 + j), 1'b0);
    chk("er_before", 32'(bus.deskew_err), 0);
    step(8'h57, 8'h67, 1'b0);
    chk("er_rise", 32'(bus.deskew_err), 1);
    chk("er_vld",  32'(bus.out_valid),  0);
    step(8'h58, 8'hF0, 1'b1);
    step(8'h59, 8'h69, 1'b1);
    chk("er_sticky", 32'(bus.deskew_err), 1);
    chk("er_l1",     32'(bus.lane_1_out), 0);
    chk("er_done",   32'(bus.deskew_done), 0);
    bus.enable_deskew = 1'b0;
    step(8'h00, 8'h00, 1'b0);
    chk("er_clear", 32'(bus.deskew_err), 0);

    // Skew 2 with data_os toggle
    bus.enable_deskew = 1'b1;
    step(8'h00, 8'h00, 1'b0);
    step(8'hF0, 8'h70, 1'b0);
    step(8'h71, 8'h71, 1'b0);
    step(8'h72, 8'hF0, 1'b0);
    chk("s2_skew", 32'(bus.skew_value), 2);
    step(8'h73, 8'h73, 1'b0);
    chk("s2_l0_sync", 32'(bus.lane_0_out), 'hF0);
    step(8'h74, 8'h74, 1'b0);
    step(8'h75, 8'h75, 1'b1);
    chk("dos_t1", 32'(bus.data_os_out), 0);
    step(8'h76, 8'h76, 1'b1);
    chk("dos_t2", 32'(bus.data_os_out), 1);
    chk_out("s2_data", 2, 0);

    // Drop enable one cycle, relock at skew 1 with lane 1 early
    bus.enable_deskew = 1'b0;
    step(8'h00, 8'h00, 1'b0);
    chk("rl_clear", all_outs(), 0);
    bus.enable_deskew = 1'b1;
    step(8'h00, 8'h00, 1'b0);
    step(8'h80, 8'hF0, 1'b0);
    step(8'hF0, 8'h81, 1'b0);
    chk("rl_skew",  32'(bus.skew_value), 1);
    chk("rl_early", 32'(bus.early_lane), 1);
    step(8'h82, 8'h82, 1'b0);
    chk("rl_l0_sync", 32'(bus.lane_0_out), 'hF0);
    chk("rl_l1_sync", 32'(bus.lane_1_out), 'hF0);
    step(8'h83, 8'h83, 1'b1);
    chk_out("rl_data", 0, 1);

    // Asynchronous reset while locked
    #2;
    rst = 1'b0;
    #1;
    chk("arst_outs", all_outs(), 0);
    step(8'hF0, 8'hF0, 1'b0);
    chk("arst_hold", all_outs(), 0);
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
